// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings {CPOL,CPHA} and the word-engine FSM states.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a single-cycle change pulse; rise/fall are edge_o qualified by q_o.
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_target_word.sv
// SPI target word engine: shifts WORD_WIDTH-bit words in/out for any CPOL/CPHA and bit order,
// back-to-back within a CS frame, flagging frames that end on a partial word.
module spi_target_word
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH  = 64,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  COPI,
  output logic                  CIPO,
  input  logic [WORD_WIDTH-1:0] word_send_data,
  output logic                  word_received,
  output logic [WORD_WIDTH-1:0] word_data_received,
  output logic [7:0]            word_count,
  output logic                  frame_error
);

  localparam int            CW       = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  logic sck_s, sck_edge, cs_s, cs_edge;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  // CS resets low so a frame already in progress at reset release is never mistaken for a start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
    .clk(clk), .reset(reset), .d_i(SCK), .q_o(sck_s), .edge_o(sck_edge)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk(clk), .reset(reset), .d_i(CS), .q_o(cs_s), .edge_o(cs_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) copi_sync_q <= '0;
    else       copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
  end
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_rise, cs_fall;

  assign lead_edge   = sck_edge & (sck_s != CPOL);
  assign trail_edge  = sck_edge & (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_rise     = cs_edge & cs_s;
  assign cs_fall     = cs_edge & ~cs_s;

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d, rx_next;
  logic [WORD_WIDTH-1:0] tx_q, tx_d, tx_shift;
  logic                  reload_q, reload_d;
  logic                  hold_q, hold_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wrecv_q, wrecv_d;
  logic [7:0]            wcount_q, wcount_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      reload_q  <= 1'b0;
      hold_q    <= 1'b0;
      wdata_q   <= '0;
      wrecv_q   <= 1'b0;
      wcount_q  <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      reload_q  <= reload_d;
      hold_q    <= hold_d;
      wdata_q   <= wdata_d;
      wrecv_q   <= wrecv_d;
      wcount_q  <= wcount_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    reload_d  = reload_q;
    hold_d    = hold_q;
    wdata_d   = wdata_q;
    wrecv_d   = 1'b0;
    wcount_d  = wcount_q;
    ferr_d    = 1'b0;
    rx_next   = MSB_FIRST ? {rx_q[WORD_WIDTH-2:0], copi_s} : {copi_s, rx_q[WORD_WIDTH-1:1]};
    tx_shift  = MSB_FIRST ? {tx_q[WORD_WIDTH-2:0], 1'b0}   : {1'b0, tx_q[WORD_WIDTH-1:1]};

    unique case (state_q)
      WAIT_IDLE: begin
        if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) begin
          tx_d     = word_send_data;
          rx_d     = '0;
          wcount_d = '0;
          reload_d = 1'b0;
          // With CPHA=1 the first leading edge only presents bit 0, which is already on CIPO.
          hold_d   = CPHA;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            wdata_d   = rx_next;
            wrecv_d   = 1'b1;
            reload_d  = 1'b1;
            if (wcount_q != 8'hFF) wcount_d = wcount_q + 8'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (shift_edge) begin
          if (hold_q)        hold_d = 1'b0;
          else if (reload_q) begin
            tx_d     = word_send_data;
            reload_d = 1'b0;
          end
          else               tx_d = tx_shift;
        end
        // Uses the post-sample count so a word completing on this very clk is not an error.
        if (cs_rise) begin
          state_d = IDLE;
          ferr_d  = (bit_cnt_d != '0);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign CIPO               = (state_q == ACTIVE) & (MSB_FIRST ? tx_q[WORD_WIDTH-1] : tx_q[0]);
  assign word_received      = wrecv_q;
  assign word_data_received = wdata_q;
  assign word_count         = wcount_q;
  assign frame_error        = ferr_q;

endmodule
